// File: rtl/button_debounce_pulse_pkg.sv
// Shared definitions for the push-button conditioning path.
// Holds the state encodings and the default timing constants used by the RTL and its bench.
package button_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM_H = 2'd1,
        ST_HIGH  = 2'd2,
        ST_ARM_L = 2'd3
    } state_e;

    localparam int DEF_DEB_CYCLES = 16;
    localparam int DEF_CNT_W      = 5;
    localparam int DEF_PULSE_LEN  = 2;

endpackage

// File: rtl/button_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for asynchronous chip inputs.
// Both stages clear to 0 on the asynchronous active-low reset.
module sync_2ff (
    input  logic CLK,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s2_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchronise, debounce on a stable-level counter, and emit a
// PULSE_LEN-cycle press pulse A that the downstream divide-by-2 FSM will always catch.
module button_debounce_pulse
    import button_debounce_pulse_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PULSE_LEN  = DEF_PULSE_LEN
) (
    input  logic CLK,
    input  logic reset,
    input  logic btn_raw,
    output logic A,
    output logic level,
    output logic busy
);

    localparam int               PC_W    = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [PC_W-1:0]  PC_LOAD = PC_W'(PULSE_LEN);

    logic             s2;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pcnt_q, pcnt_d;
    logic             a_q, a_d;
    logic             press;

    sync_2ff u_sync (
        .CLK   (CLK),
        .reset (reset),
        .d     (btn_raw),
        .q     (s2)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            a_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            a_q     <= a_d;
        end
    end

    // Any s2 change while arming drops back to the stable state; cnt clears on every move.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s2) begin
                    state_d = ST_ARM_H;
                    cnt_d   = '0;
                end
            end
            ST_ARM_H: begin
                if (!s2) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!s2) begin
                    state_d = ST_ARM_L;
                    cnt_d   = '0;
                end
            end
            ST_ARM_L: begin
                if (s2) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The pulse runs to completion regardless of later state changes.
    always_comb begin
        pcnt_d = pcnt_q;
        if (press)
            pcnt_d = PC_LOAD;
        else if (pcnt_q != '0)
            pcnt_d = pcnt_q - 1'b1;
        a_d = (pcnt_d != '0);
    end

    assign A     = a_q;
    assign level = (state_q == ST_HIGH) || (state_q == ST_ARM_L);
    assign busy  = (state_q == ST_ARM_H) || (state_q == ST_ARM_L);

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse: reset, clean/bouncy presses, release glitch,
// repeated presses with a divide-by-2 toggle consumer, and reset during a pulse.
module tb_button_debounce_pulse;
    import button_debounce_pulse_pkg::*;

    localparam int D = DEF_DEB_CYCLES;
    localparam int P = DEF_PULSE_LEN;

    logic CLK, reset, btn_raw;
    logic A, level, busy;
    int   checks = 0;
    int   errors = 0;

    button_debounce_pulse #(
        .DEB_CYCLES (DEF_DEB_CYCLES),
        .CNT_W      (DEF_CNT_W),
        .PULSE_LEN  (DEF_PULSE_LEN)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .btn_raw (btn_raw),
        .A       (A),
        .level   (level),
        .busy    (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic pulse_exp(input int e);
        return (e >= D + 2) && (e < D + 2 + P);
    endfunction

    int  npulse, nhigh;
    logic tgl, tgl_en, a_smp;

    initial begin
        reset   = 1'b1;
        btn_raw = 1'b1;
        #3 reset = 1'b0;

        // 1. Reset held three cycles with the button already pressed
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_A_%0d", i), A, 1'b0);
            chk($sformatf("rst_level_%0d", i), level, 1'b0);
            chk($sformatf("rst_busy_%0d", i), busy, 1'b0);
        end
        reset = 1'b1;
        for (int e = 0; e < 25; e++) begin
            step();
            chk($sformatf("t1_A_e%0d", e), A, pulse_exp(e));
            chk($sformatf("t1_level_e%0d", e), level, e >= D + 2);
        end

        // Release back to IDLE
        btn_raw = 1'b0;
        for (int e = 0; e < 25; e++) begin
            step();
            chk($sformatf("rel_level_e%0d", e), level, e < D + 2);
            chk($sformatf("rel_busy_e%0d", e), busy, (e >= 2) && (e < D + 2));
            chk($sformatf("rel_A_e%0d", e), A, 1'b0);
        end

        // 2. Clean press held 40 cycles
        btn_raw = 1'b1;
        for (int e = 0; e < 40; e++) begin
            step();
            chk($sformatf("t2_A_e%0d", e), A, pulse_exp(e));
            chk($sformatf("t2_level_e%0d", e), level, e >= D + 2);
            chk($sformatf("t2_busy_e%0d", e), busy, (e >= 2) && (e < D + 2));
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 25; i++) step();
        chk("t2_back_idle", level, 1'b0);

        // 3. Bouncy press: toggle every 3 cycles for 30 cycles, then hold high
        for (int seg = 0; seg < 10; seg++) begin
            btn_raw = (seg % 2 == 0);
            for (int i = 0; i < 3; i++) begin
                step();
                chk($sformatf("t3_bnc_A_%0d_%0d", seg, i), A, 1'b0);
                chk($sformatf("t3_bnc_level_%0d_%0d", seg, i), level, 1'b0);
            end
        end
        btn_raw = 1'b1;
        for (int e = 0; e < 26; e++) begin
            step();
            chk($sformatf("t3_A_e%0d", e), A, pulse_exp(e));
            chk($sformatf("t3_level_e%0d", e), level, e >= D + 2);
        end

        // 4. Release glitch of 5 cycles while HIGH
        btn_raw = 1'b0;
        for (int e = 0; e < 16; e++) begin
            if (e == 5) btn_raw = 1'b1;
            step();
            chk($sformatf("t4_level_e%0d", e), level, 1'b1);
            chk($sformatf("t4_A_e%0d", e), A, 1'b0);
            chk($sformatf("t4_busy_e%0d", e), busy, (e >= 2) && (e <= 6));
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 25; i++) step();
        chk("t4_back_idle", level, 1'b0);

        // 5. Three press/release pairs feeding a divide-by-2 toggle consumer
        npulse = 0;
        nhigh  = 0;
        tgl    = 1'b0;
        tgl_en = 1'b0;
        a_smp  = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                btn_raw = (ph == 0);
                for (int e = 0; e < 25; e++) begin
                    step();
                    if (ph == 0) begin
                        chk($sformatf("t5_A_p%0d_e%0d", p, e), A, pulse_exp(e));
                        chk($sformatf("t5_level_p%0d_e%0d", p, e), level, e >= D + 2);
                    end else begin
                        chk($sformatf("t5_relA_p%0d_e%0d", p, e), A, 1'b0);
                        chk($sformatf("t5_rellvl_p%0d_e%0d", p, e), level, e < D + 2);
                    end
                    if (A) nhigh++;
                    if (tgl_en) begin
                        if (A && !a_smp) begin
                            tgl = ~tgl;
                            npulse++;
                        end
                        a_smp = A;
                    end
                    tgl_en = ~tgl_en;
                end
            end
        end
        chk("t5_npulse", npulse == 3, 1'b1);
        chk("t5_nhigh", nhigh == 3 * P, 1'b1);
        chk("t5_toggle", tgl, 1'b1);

        // 6. Reset on the cycle A first rises
        btn_raw = 1'b1;
        for (int e = 0; e <= D + 2; e++) begin
            step();
            chk($sformatf("t6_A_e%0d", e), A, pulse_exp(e));
        end
        reset   = 1'b0;
        btn_raw = 1'b0;
        #1;
        chk("t6_async_A", A, 1'b0);
        chk("t6_async_level", level, 1'b0);
        chk("t6_async_busy", busy, 1'b0);
        step();
        step();
        reset = 1'b1;
        for (int e = 0; e < 30; e++) begin
            step();
            chk($sformatf("t6_post_A_e%0d", e), A, 1'b0);
            chk($sformatf("t6_post_level_e%0d", e), level, 1'b0);
            chk($sformatf("t6_post_busy_e%0d", e), busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
